// File: rtl/shift_unit_seq.sv
`default_nettype none
// ============================================================================
// Module      : shift_unit_seq
// Description : Multi-cycle barrel-lite shifter for the MIPS datapath.
//               Performs SLL / SRL / SRA / ROTR on a WIDTH-bit operand,
//               moving at most STEP bit positions per clock, behind a
//               start / busy / done handshake driven by the EX controller.
// Ports       :
//   clk    in   1      rising-edge clock
//   rst    in   1      synchronous reset, active-high
//   start  in   1      request; accepted when start=1 and busy=0
//   mode   in   2      00 SLL, 01 SRL, 10 SRA, 11 ROTR (rotate right)
//   din    in   WIDTH  operand, sampled at acceptance
//   shamt  in   SHW    shift amount 0..WIDTH-1, sampled at acceptance
//   busy   out  1      high while the shift is in progress
//   done   out  1      one-cycle pulse; dout holds the new result
//   dout   out  WIDTH  last completed result, held until the next completion
// Revision    : 1.0  initial release
// ============================================================================
module shift_unit_seq #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [1:0]                 mode,
    input  logic [WIDTH-1:0]           din,
    input  logic [$clog2(WIDTH)-1:0]   shamt,
    output logic                       busy,
    output logic                       done,
    output logic [WIDTH-1:0]           dout
);

    localparam int SHW = $clog2(WIDTH);
    // One extra bit so STEP == WIDTH is representable for the min() compare.
    localparam int KW  = SHW + 1;
    localparam logic [KW-1:0] c_step = KW'(STEP);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] c_mode_sll  = 2'b00;
    localparam logic [1:0] c_mode_sra  = 2'b10;
    localparam logic [1:0] c_mode_rotr = 2'b11;

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [WIDTH-1:0] r_work;
    logic [SHW-1:0]   r_rem;
    logic [1:0]       r_mode;
    logic             r_sign;
    logic [WIDTH-1:0] r_dout;

    logic             w_accept;
    logic [SHW-1:0]   w_k;
    logic [SHW-1:0]   w_rem_next;
    logic [2*WIDTH-1:0] w_ext;
    logic [WIDTH-1:0] w_shifted;

    assign w_accept = start && (r_state != S_RUN);

    // k = min(STEP, rem). When rem < STEP the low SHW bits of STEP are
    // never selected, so STEP == WIDTH (which wraps to 0 in SHW bits) is safe.
    assign w_k        = ({1'b0, r_rem} < c_step) ? r_rem : c_step[SHW-1:0];
    assign w_rem_next = r_rem - w_k;

    // Right-type shifts share one double-width shifter: the upper half
    // supplies the fill (zeros, captured sign, or the word itself to rotate).
    always_comb begin
        w_ext = {{WIDTH{1'b0}}, r_work};
        case (r_mode)
            c_mode_sra:  w_ext = {{WIDTH{r_sign}}, r_work};
            c_mode_rotr: w_ext = {r_work, r_work};
            default:     w_ext = {{WIDTH{1'b0}}, r_work};
        endcase
    end

    always_comb begin
        w_shifted = WIDTH'(w_ext >> w_k);
        if (r_mode == c_mode_sll) begin
            w_shifted = r_work << w_k;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = S_IDLE;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    w_state_next = (shamt == '0) ? S_DONE : S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_RUN: begin
                w_state_next = (w_rem_next == '0) ? S_DONE : S_RUN;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: capture on acceptance, step while running. dout is only
    // written on the edge that enters DONE so partial results never leak.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_work <= '0;
            r_rem  <= '0;
            r_mode <= '0;
            r_sign <= 1'b0;
            r_dout <= '0;
        end else if (w_accept) begin
            r_work <= din;
            r_rem  <= shamt;
            r_mode <= mode;
            r_sign <= din[WIDTH-1];
            if (shamt == '0) begin
                r_dout <= din;
            end
        end else if (r_state == S_RUN) begin
            r_work <= w_shifted;
            r_rem  <= w_rem_next;
            if (w_rem_next == '0) begin
                r_dout <= w_shifted;
            end
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);
    assign dout = r_dout;

endmodule
`default_nettype wire
